// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and RAM depth.
// Also holds the byte-enable helper so every user decodes lanes the same way.
package lsu_pkg;

    localparam int MEM_WORDS = 32768;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Illegal size maps to no lanes so a rejected access can never write.
    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            SIZE_B:  be = 4'b0001 << offset;
            SIZE_H:  be = 4'b0011 << offset;
            SIZE_W:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data aligner: picks the addressed byte/half out of a RAM word and extends it.
// Purely combinational so the fetch-side debug port can share it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_mem_q,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_rdata
);

    logic [31:0] w_lane;
    logic        w_sign;

    always_comb begin
        w_lane = i_mem_q >> {i_offset, 3'b000};
        w_sign = 1'b0;
        case (i_size)
            SIZE_B: begin
                w_sign  = ~i_unsigned & w_lane[7];
                o_rdata = {{24{w_sign}}, w_lane[7:0]};
            end
            SIZE_H: begin
                w_sign  = ~i_unsigned & w_lane[15];
                o_rdata = {{16{w_sign}}, w_lane[15:0]};
            end
            default: o_rdata = w_lane;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit bridging the execute stage to RAM port A (word addressed, byte enabled).
// One access at a time; loads take two cycles because the RAM registers its read address.
module lsu
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_wren,
    output logic [29:0] mem_address,
    output logic [31:0] mem_data,
    output logic [3:0]  mem_byteena,
    input  logic [31:0] mem_q
);

    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_offset;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_accept;
    logic        w_err;
    logic [31:0] w_aligned;

    always_comb begin
        w_err = (req_size == 2'd3)
              | ((req_size == SIZE_H) & req_addr[0])
              | ((req_size == SIZE_W) & (req_addr[1:0] != 2'b00))
              | (req_addr[31:2] >= WORD_LIMIT);
    end

    assign w_accept = req_valid & req_ready;

    // The RAM samples address and write controls on the accept edge itself.
    assign mem_address = req_addr[31:2];
    assign mem_byteena = byte_enables(req_size, req_addr[1:0]);
    assign mem_wren    = w_accept & req_we & ~w_err & rst_n;

    always_comb begin
        case (req_size)
            SIZE_B:  mem_data = {4{req_wdata[7:0]}};
            SIZE_H:  mem_data = {2{req_wdata[15:0]}};
            default: mem_data = req_wdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_RESP: begin
                if (w_accept) begin
                    w_next = (req_we | w_err) ? ST_RESP : ST_DATA;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_DATA: w_next = ST_RESP;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = rst_n & (r_state != ST_DATA);
        resp_valid = (r_state == ST_RESP);
    end

    lsu_load_align u_align (
        .i_mem_q    (mem_q),
        .i_offset   (r_offset),
        .i_size     (r_size),
        .i_unsigned (r_unsigned),
        .o_rdata    (w_aligned)
    );

    // A pending load's result only overwrites the previous response when DATA completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_size     <= SIZE_B;
            r_unsigned <= 1'b0;
            r_offset   <= 2'b00;
            r_rdata    <= 32'd0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_size     <= req_size;
            r_unsigned <= req_unsigned;
            r_offset   <= req_addr[1:0];
            if (req_we | w_err) begin
                r_rdata <= 32'd0;
                r_err   <= w_err;
            end
        end else if (r_state == ST_DATA) begin
            r_rdata <= w_aligned;
            r_err   <= 1'b0;
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: behavioural RAM plus a byte-level memory model that predicts every response.
// Directed test-plan steps followed by a randomized request stream.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_wren;
    logic [29:0] mem_address;
    logic [31:0] mem_data;
    logic [3:0]  mem_byteena;
    logic [31:0] mem_q;

    int n_pass  = 0;
    int n_total = 0;

    lsu dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_wren     (mem_wren),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_byteena  (mem_byteena),
        .mem_q        (mem_q)
    );

    always #5 clk = ~clk;

    // RAM with registered read address and byte-enabled writes.
    logic [31:0] ram [0:32767];
    logic [14:0] ram_raddr = 15'd0;

    always @(posedge clk) begin
        if (mem_wren) begin
            for (int k = 0; k < 4; k++) begin
                if (mem_byteena[k]) ram[mem_address[14:0]][8*k +: 8] <= mem_data[8*k +: 8];
            end
        end
        ram_raddr <= mem_address[14:0];
    end
    assign mem_q = ram[ram_raddr];

    // Reference model: a sparse byte-addressed memory, zero where never written.
    logic [7:0] bmem [bit [31:0]];

    function automatic logic [7:0] get_byte(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : 8'h00;
    endfunction

    function automatic int size_bytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd3) return 1'b1;
        if (a % size_bytes(sz) != 0) return 1'b1;
        if ((a / 4) >= 32768) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input logic [31:0] a);
        logic [31:0] v;
        int n;
        n = size_bytes(sz);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(get_byte(a + 32'(i))) << (8 * i));
        if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < size_bytes(sz); i++) bmem[a + 32'(i)] = wd[8*i +: 8];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid    = v;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
    endtask

    // One isolated request from IDLE, checked against the model; returns resp_rdata.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
        logic        e;
        logic [3:0]  be;
        logic [31:0] md;
        logic [31:0] exp_rd;
        int          n;
        e = model_err(sz, a);
        n = size_bytes(sz);
        be = 4'b0000;
        md = 32'd0;
        for (int i = 0; i < n; i++) be[(a % 4) + 32'(i)] = 1'b1;
        for (int k = 0; k < 4; k++) md[8*k +: 8] = wd[8*(k % n) +: 8];
        exp_rd = (we || e) ? 32'd0 : model_load(sz, uns, a);

        @(negedge clk);
        drive(1'b1, we, sz, uns, a, wd);
        #1;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        chk("mem_wren", 32'(mem_wren), 32'(we && !e));
        chk("mem_address", 32'(mem_address), a >> 2);
        if (!e) chk("mem_byteena", 32'(mem_byteena), 32'(be));
        if (we && !e) chk("mem_data", mem_data, md);
        @(posedge clk);
        #1 req_valid = 1'b0;
        if (we && !e) model_store(sz, a, wd);
        @(negedge clk);
        if (!we && !e) begin
            chk("load_data_cycle_valid", 32'(resp_valid), 32'd0);
            chk("load_data_cycle_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        chk("resp_valid", 32'(resp_valid), 32'd1);
        chk("resp_err", 32'(resp_err), 32'(e));
        chk("resp_rdata", resp_rdata, exp_rd);
        rd = resp_rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] x_data;
        logic [31:0] y_data;

        for (int w = 0; w < 32768; w++) ram[w] = 32'd0;

        // Reset with a legal store held on the request bus.
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h100, 32'h1234_5678);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_mem_wren", 32'(mem_wren), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_mem_wren_edge", 32'(mem_wren), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        rst_n = 1'b1;
        #1 chk("post_rst_ready", 32'(req_ready), 32'd1);

        // Directed test-plan steps.
        do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEAD_BEEF, rd);
        do_req(1'b1, 2'd0, 1'b0, 32'h101, 32'h1234_56A5, rd);
        do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'd0, rd);
        chk("lw_0x100_const", rd, 32'hDEAD_A5EF);
        do_req(1'b0, 2'd0, 1'b0, 32'h101, 32'd0, rd);
        chk("lb_0x101_const", rd, 32'hFFFF_FFA5);
        do_req(1'b0, 2'd0, 1'b1, 32'h101, 32'd0, rd);
        chk("lbu_0x101_const", rd, 32'h0000_00A5);
        do_req(1'b0, 2'd1, 1'b0, 32'h102, 32'd0, rd);
        chk("lh_0x102_const", rd, 32'hFFFF_DEAD);
        do_req(1'b0, 2'd1, 1'b1, 32'h102, 32'd0, rd);
        chk("lhu_0x102_const", rd, 32'h0000_DEAD);
        do_req(1'b0, 2'd1, 1'b0, 32'h103, 32'd0, rd);
        do_req(1'b1, 2'd2, 1'b0, 32'h102, 32'hFFFF_FFFF, rd);
        do_req(1'b0, 2'd3, 1'b0, 32'h100, 32'd0, rd);
        do_req(1'b0, 2'd2, 1'b0, 32'h2_0000, 32'd0, rd);
        do_req(1'b1, 2'd2, 1'b0, 32'h1_FFFC, 32'hCAFE_F00D, rd);
        do_req(1'b0, 2'd2, 1'b0, 32'h1_FFFC, 32'd0, rd);
        chk("lw_last_word_const", rd, 32'hCAFE_F00D);

        // Back-to-back: LW, then a held SW accepted only in RESP, then another SW.
        x_data = 32'h0BAD_F00D;
        y_data = 32'h5A5A_1234;
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
        @(posedge clk);
        #1 drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h104, x_data);
        @(negedge clk);
        chk("b2b_data_ready", 32'(req_ready), 32'd0);
        chk("b2b_data_wren", 32'(mem_wren), 32'd0);
        chk("b2b_data_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("b2b_load_valid", 32'(resp_valid), 32'd1);
        chk("b2b_load_rdata", resp_rdata, model_load(2'd2, 1'b0, 32'h100));
        chk("b2b_resp_ready", 32'(req_ready), 32'd1);
        chk("b2b_store1_wren", 32'(mem_wren), 32'd1);
        @(posedge clk);
        model_store(2'd2, 32'h104, x_data);
        #1 drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h108, y_data);
        @(negedge clk);
        chk("b2b_store1_valid", 32'(resp_valid), 32'd1);
        chk("b2b_store1_rdata", resp_rdata, 32'd0);
        chk("b2b_store2_wren", 32'(mem_wren), 32'd1);
        @(posedge clk);
        model_store(2'd2, 32'h108, y_data);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("b2b_store2_valid", 32'(resp_valid), 32'd1);
        @(negedge clk);
        chk("b2b_idle_valid", 32'(resp_valid), 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h104, 32'd0, rd);
        chk("b2b_readback_x", rd, x_data);
        do_req(1'b0, 2'd2, 1'b0, 32'h108, 32'd0, rd);
        chk("b2b_readback_y", rd, y_data);

        // Reset pulse during DATA drops the pending load response.
        @(negedge clk);
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
        @(posedge clk);
        #1 drive(1'b1, 1'b1, 2'd2, 1'b0, 32'h10C, 32'h7777_7777);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_ready", 32'(req_ready), 32'd0);
        chk("midrst_wren", 32'(mem_wren), 32'd0);
        chk("midrst_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        chk("midrst_valid2", 32'(resp_valid), 32'd0);
        chk("midrst_wren2", 32'(mem_wren), 32'd0);
        chk("midrst_rdata", resp_rdata, 32'd0);
        req_valid = 1'b0;
        rst_n = 1'b1;
        #1 chk("midrst_release_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("midrst_no_pulse", 32'(resp_valid), 32'd0);
        chk("midrst_idle_ready", 32'(req_ready), 32'd1);
        do_req(1'b0, 2'd2, 1'b0, 32'h10C, 32'd0, rd);

        // Randomized stream against the byte model.
        for (int t = 0; t < 300; t++) begin
            logic        we;
            logic        uns;
            logic [1:0]  sz;
            logic [31:0] a;
            int          r;
            int          s;
            we  = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 15);
            sz = (r < 5) ? 2'd0 : (r < 10) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
            s = $urandom_range(0, 19);
            if (s == 0) a = 32'h2_0000 + 32'($urandom_range(0, 15));
            else if (s == 1) a = $urandom;
            else a = 32'($urandom_range(0, 127));
            do_req(we, sz, uns, a, $urandom, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
